seq_mag_comp: RTL and testbench
===============================

# seq_mag_comp

Parametrised, multi-cycle magnitude comparator: the successor to the 4-bit combinational comparator. It compares two WIDTH-bit operands DIGIT bits per cycle, most-significant digit first, and terminates early at the first differing digit. A per-request mode selects signed or unsigned comparison. It sits on datapaths where wide operands make a single-cycle compare too slow, and talks to its requester through a start/busy/done handshake.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits compared per cycle; 1 ≤ DIGIT ≤ WIDTH.
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  reset, **synchronous, active-high**.
- start  input  1  request; accepted only when busy=0.
- A  input  WIDTH  operand A, sampled on the accepted start.
- B  input  WIDTH  operand B, sampled on the accepted start.
- is_signed  input  1  1 = two's-complement compare; 0 = unsigned. Sampled with start.
- busy  output  1  a compare is in progress.
- done  output  1  one-cycle pulse; result flags are valid.
- A_gt_b  output  1  result: A > B.
- A_lt_b  output  1  result: A < B.
- A_eq_b  output  1  result: A == B.

## Operation
- NUM_DIGITS = WIDTH/DIGIT. Digit index register width is max(1, $clog2(NUM_DIGITS)).
- **States:**
  - IDLE: busy=0.
  - CMP: busy=1.
- **IDLE → CMP** on start=1.
  - Latch A and B into internal operand registers.
  - If is_signed=1, invert the MSB of both latched operands. After that, the signed compare is an unsigned compare.
  - Set the index to NUM_DIGITS-1.
- **CMP, each cycle:** compare digit[index] of the latched A against the same digit of the latched B, unsigned.
  - Digits differ: register gt/lt from this digit, set eq=0, pulse done, go to IDLE.
  - Digits equal and index==0: register eq=1, gt=lt=0, pulse done, go to IDLE.
  - Otherwise: decrement the index and stay in CMP.
- Result flags are one-hot after any completion and hold until the next completion or reset. They do not change during a compare.
- start while busy=1 is ignored. It is not queued and the latched operands are not disturbed.
- A, B and is_signed may change freely after acceptance.
- **Reset:**
  - Values: state=IDLE, busy=0, done=0, A_gt_b=A_lt_b=A_eq_b=0. All-zero flags mean "no result yet".
  - Reset mid-compare aborts the compare. No done is produced and the flags are cleared.
  - rst takes priority over start in the same cycle.

## Timing
- Start accepted at edge t0: busy=1 from t0.
- Digit i (1-based, MSB first) is evaluated in the cycle following edge t0+i-1.
- Decision at edge t0+k, where k = position of the first differing digit, or NUM_DIGITS if the operands are equal. At that edge: flags updated, done=1, busy=0. done=0 at t0+k+1.
- Latency: 1..NUM_DIGITS cycles.
  - Equal operands always take NUM_DIGITS cycles.
  - DIGIT==WIDTH gives a fixed 1-cycle compare.
- **Back-to-back:** start may be high in the done cycle and is accepted at edge t0+k. Throughput is one compare per k cycles.

## Structure
- Shared package mag_comp_pkg holds:
  - the state enum (IDLE, CMP);
  - the result encoding constants (GT, LT, EQ bit positions);
  - a NUM_DIGITS helper function.
- One sub-module, mag_comp_digit: combinational DIGIT-bit unsigned compare with outputs gt, lt, eq. It is instantiated once on the index-selected digit slice.
- Top level contains the FSM, operand registers, index counter and result registers.

## Test plan
All scenarios use WIDTH=16, DIGIT=4.

- **Reset:** hold rst 2 cycles → busy=0, done=0, all three flags 0. Start held high during rst is not accepted.
- **Equal:** A=0x1234, B=0x1234, unsigned → done exactly 4 cycles after the start edge, A_eq_b=1, others 0.
- **Early exit:** A=0x0100, B=0x00FF → A_gt_b=1 after 2 cycles. A=0x00F1, B=0x00F2 → A_lt_b=1 after 4 cycles. A=0xF000, B=0x0FFF → A_gt_b=1 after 1 cycle.
- **Signed mode:**
  - A=0x8000, B=0x7FFF, is_signed=0 → A_gt_b=1 after 1 cycle.
  - Same operands, is_signed=1 → A_lt_b=1 after 1 cycle.
  - A=0xFFFF, B=0xFFFE, signed → A_gt_b=1 (-1 > -2).
- **Handshake:**
  - Start pulsed mid-compare with different A/B → ignored; the original result is reported.
  - Start held high on the done cycle → second compare accepted, busy stays 1, second done at the correct latency.
- **Abort:** assert rst 2 cycles into an equal-operand compare → busy=0 and flags cleared next edge; no done pulse ever appears; the next compare behaves normally.

Source files
------------

// File: rtl/mag_comp_pkg.sv
// Shared definitions for the sequential magnitude comparator.
//   state_e     : controller states (IDLE, CMP)
//   RES_*       : bit positions of the GT/LT/EQ flags in the result vector
//   num_digits  : number of DIGIT-wide slices in a WIDTH-bit operand
package mag_comp_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CMP  = 1'b1
  } state_e;

  localparam int RES_EQ = 0;
  localparam int RES_LT = 1;
  localparam int RES_GT = 2;
  localparam int RES_W  = 3;

  function automatic int num_digits(input int width, input int digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/mag_comp_digit.sv
// Combinational unsigned compare of one DIGIT-bit slice.
//   a, b : digit operands
//   gt   : a > b
//   lt   : a < b
//   eq   : a == b
module mag_comp_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  assign gt = (a > b);
  assign lt = (a < b);
  assign eq = (a == b);

endmodule

// File: rtl/seq_mag_comp.sv
// Multi-cycle magnitude comparator. Compares A and B one DIGIT-bit slice per
// cycle, most-significant slice first, stopping at the first differing slice.
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   start      : request, taken when idle or on the decision cycle
//   A, B       : operands, sampled when the request is taken
//   is_signed  : 1 = two's-complement compare, sampled with the request
//   busy       : a compare is in progress
//   done       : one-cycle pulse, result flags freshly updated
//   A_gt_b/A_lt_b/A_eq_b : one-hot result, held until the next completion
module seq_mag_comp
  import mag_comp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             is_signed,
  output logic             busy,
  output logic             done,
  output logic             A_gt_b,
  output logic             A_lt_b,
  output logic             A_eq_b
);

  localparam int ND = num_digits(WIDTH, DIGIT);
  localparam int IW = (ND > 1) ? $clog2(ND) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(ND - 1);

  state_e                     state;
  logic [IW-1:0]              idx;
  logic [ND-1:0][DIGIT-1:0]   a_q;
  logic [ND-1:0][DIGIT-1:0]   b_q;
  logic [RES_W-1:0]           res;
  logic [RES_W-1:0]           res_nxt;
  logic [WIDTH-1:0]           msb_mask;
  logic                       d_gt, d_lt, d_eq;
  logic                       last;
  logic                       accept;

  // Flipping the sign bit of both operands maps two's-complement order onto
  // unsigned order, so the digit compare below never needs to know the mode.
  assign msb_mask = WIDTH'(is_signed) << (WIDTH - 1);

  mag_comp_digit #(.DIGIT(DIGIT)) u_digit (
    .a  (a_q[idx]),
    .b  (b_q[idx]),
    .gt (d_gt),
    .lt (d_lt),
    .eq (d_eq)
  );

  // Decision cycle: first differing digit, or the final digit when all match.
  assign last = (state == CMP) && (!d_eq || (idx == '0));

  // A request on the decision cycle is taken immediately so back-to-back
  // compares keep busy high; requests on other compare cycles are dropped.
  assign accept = start && ((state == IDLE) || last);

  always_comb begin
    res_nxt         = '0;
    res_nxt[RES_GT] = d_gt;
    res_nxt[RES_LT] = d_lt;
    res_nxt[RES_EQ] = d_eq;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      res   <= '0;
      done  <= 1'b0;
    end else begin
      done <= last;
      if (last) res <= res_nxt;

      if (accept) begin
        a_q   <= A ^ msb_mask;
        b_q   <= B ^ msb_mask;
        idx   <= IDX_TOP;
        state <= CMP;
      end else if (last) begin
        state <= IDLE;
      end else if (state == CMP) begin
        idx <= idx - 1'b1;
      end
    end
  end

  assign busy   = (state == CMP);
  assign A_gt_b = res[RES_GT];
  assign A_lt_b = res[RES_LT];
  assign A_eq_b = res[RES_EQ];

endmodule

// File: tb/tb_seq_mag_comp.sv
// Self-checking bench for seq_mag_comp (WIDTH=16, DIGIT=4). A reference model
// predicts each accepted request's result and completion cycle from plain
// integer arithmetic; a monitor compares every done pulse against the queue.
module tb_seq_mag_comp;

  localparam int WIDTH = 16;
  localparam int DIGIT = 4;
  localparam int ND    = WIDTH / DIGIT;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] A, B;
  logic             is_signed;
  logic             busy, done, A_gt_b, A_lt_b, A_eq_b;

  seq_mag_comp #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .A         (A),
    .B         (B),
    .is_signed (is_signed),
    .busy      (busy),
    .done      (done),
    .A_gt_b    (A_gt_b),
    .A_lt_b    (A_lt_b),
    .A_eq_b    (A_eq_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] flags;   // {gt, lt, eq}
    int         due;     // edge count at which done must appear
  } exp_t;

  exp_t       sbq[$];
  logic [2:0] exp_flags = 3'b000;
  bit         m_busy    = 1'b0;
  int         m_rem     = 0;
  int         cyc       = 0;
  int         checks    = 0;
  int         errors    = 0;

  // Number of cycles until a decision: 1-based position of the first
  // differing 4-bit digit counting from the top, or ND if equal.
  function automatic int first_diff(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int x;
    x = int'(a ^ b);
    for (int p = 1; p <= ND; p++)
      if (((x >> ((ND - p) * DIGIT)) & 15) != 0) return p;
    return ND;
  endfunction

  function automatic logic [2:0] ref_flags(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                           input logic s);
    int x, y;
    x = s ? int'($signed(a)) : int'(a);
    y = s ? int'($signed(b)) : int'(b);
    if (x > y) return 3'b100;
    if (x < y) return 3'b010;
    return 3'b001;
  endfunction

  // Reference model: evaluated on each rising edge from the inputs driven
  // during the preceding cycle.
  always @(posedge clk) begin : model
    bit was_busy;
    bit decide;
    int k;
    cyc++;
    if (rst) begin
      m_busy = 1'b0;
      m_rem  = 0;
      sbq.delete();
      exp_flags = 3'b000;
    end else begin
      was_busy = m_busy;
      decide   = m_busy && (m_rem == 1);
      if (m_busy) begin
        m_rem--;
        if (decide) m_busy = 1'b0;
      end
      if (start && (!was_busy || decide)) begin
        k = first_diff(A, B);
        sbq.push_back('{ref_flags(A, B, is_signed), cyc + k});
        m_busy = 1'b1;
        m_rem  = k;
      end
    end
  end

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    checks++;
    if (busy !== m_busy) begin
      errors++;
      $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, m_busy);
    end
    if (done === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done cyc=%0d got done=1 want no pending request", cyc);
      end else begin
        e = sbq.pop_front();
        exp_flags = e.flags;
        checks++;
        if ({A_gt_b, A_lt_b, A_eq_b} !== e.flags) begin
          errors++;
          $display("FAIL result cyc=%0d got=%b want=%b", cyc, {A_gt_b, A_lt_b, A_eq_b}, e.flags);
        end
        checks++;
        if (cyc != e.due) begin
          errors++;
          $display("FAIL done_cycle got=%0d want=%0d", cyc, e.due);
        end
      end
    end else if (done !== 1'b0) begin
      checks++; errors++;
      $display("FAIL done_x cyc=%0d got=%b want=0", cyc, done);
    end
    checks++;
    if ({A_gt_b, A_lt_b, A_eq_b} !== exp_flags) begin
      errors++;
      $display("FAIL flags_hold cyc=%0d got=%b want=%b", cyc, {A_gt_b, A_lt_b, A_eq_b}, exp_flags);
    end
  end

  task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  // Drive a one-cycle request; returns at the falling edge after acceptance.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
    @(negedge clk);
    A = a; B = b; is_signed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = 16'($urandom); B = 16'($urandom); is_signed = 1'($urandom);
  endtask

  // Wait (bounded) for done; n0 = edges already elapsed since acceptance.
  task automatic wait_done(input int n0, input int lat, input logic [2:0] fl, input string nm);
    int n;
    n = n0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) break;
    end
    checks++;
    if (n != lat) begin
      errors++;
      $display("FAIL %s_latency got=%0d want=%0d", nm, n, lat);
    end
    chk({nm, "_flags"}, {1'b0, A_gt_b, A_lt_b, A_eq_b}, {1'b0, fl});
  endtask

  task automatic run_dir(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s,
                         input int lat, input logic [2:0] fl, input string nm);
    issue(a, b, s);
    wait_done(0, lat, fl, nm);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [WIDTH-1:0] mask;

    // Reset held two cycles with start asserted: nothing may be accepted.
    rst = 1'b1; start = 1'b1; A = 16'h1234; B = 16'h1234; is_signed = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy",  {3'b0, busy}, 4'h0);
    chk("reset_done",  {3'b0, done}, 4'h0);
    chk("reset_flags", {1'b0, A_gt_b, A_lt_b, A_eq_b}, 4'h0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);

    run_dir(16'h1234, 16'h1234, 1'b0, 4, 3'b001, "equal");
    run_dir(16'h0100, 16'h00FF, 1'b0, 2, 3'b100, "exit2");
    run_dir(16'h00F1, 16'h00F2, 1'b0, 4, 3'b010, "exit4");
    run_dir(16'hF000, 16'h0FFF, 1'b0, 1, 3'b100, "exit1");
    run_dir(16'h8000, 16'h7FFF, 1'b0, 1, 3'b100, "unsigned_msb");
    run_dir(16'h8000, 16'h7FFF, 1'b1, 1, 3'b010, "signed_msb");
    run_dir(16'hFFFF, 16'hFFFE, 1'b1, 4, 3'b100, "signed_neg");

    // Start pulsed mid-compare with other operands must be ignored.
    issue(16'h1234, 16'h1234, 1'b0);
    @(negedge clk);
    A = 16'hFFFF; B = 16'h0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(2, 4, 3'b001, "ignore_mid");

    // Start held into the decision edge: second request taken back-to-back.
    @(negedge clk);
    A = 16'h0100; B = 16'h00FF; is_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    A = 16'h00F1; B = 16'h00F2;
    repeat (2) @(negedge clk);
    chk("b2b_done1", {3'b0, done}, 4'h1);
    chk("b2b_busy",  {3'b0, busy}, 4'h1);
    chk("b2b_flags1", {1'b0, A_gt_b, A_lt_b, A_eq_b}, 4'b0100);
    start = 1'b0;
    wait_done(0, 4, 3'b010, "b2b_second");

    // Reset two cycles into an equal compare aborts it silently.
    issue(16'h5A5A, 16'h5A5A, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy",  {3'b0, busy}, 4'h0);
    chk("abort_flags", {1'b0, A_gt_b, A_lt_b, A_eq_b}, 4'h0);
    repeat (6) @(negedge clk);
    run_dir(16'h0F00, 16'h0E00, 1'b0, 2, 3'b100, "after_abort");

    // Random traffic, operands biased to share upper digits so every
    // latency is exercised; occasional resets.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 199) == 0);
      start     = ($urandom_range(0, 2) == 0);
      A         = 16'($urandom);
      mask      = 16'($urandom) >> $urandom_range(0, 16);
      B         = A ^ mask;
      is_signed = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    for (int i = 0; i < 10 && busy !== 1'b0; i++) @(negedge clk);
    repeat (2) @(negedge clk);

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL pending_results got=%0d want=0", sbq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
